// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the divided-clock monitor
package div_pkg;

    localparam int DIV_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        MEAS   = 2'd2,
        LOCKED = 2'd3
    } div_state_t;

    // Sampling in the fast domain can land the high time on either half of an odd ratio.
    function automatic logic good_high(input logic [31:0] exp_n, input logic [31:0] high);
        return (high == (exp_n >> 1)) || (high == ((exp_n + 32'd1) >> 1));
    endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// rtl/div_clk_monitor_if.sv - control/status bundle between the monitor and its user
interface div_clk_monitor_if #(
    parameter int CNT_W = div_pkg::DIV_CNT_W
);
    logic             en;
    logic [CNT_W-1:0] exp_period;
    logic             mon_clk;
    logic             err_clr;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid;
    logic             locked;
    logic             err;

    modport master (
        output en, exp_period, mon_clk, err_clr,
        input  period_o, high_o, meas_valid, locked, err
    );

    modport slave (
        input  en, exp_period, mon_clk, err_clr,
        output period_o, high_o, meas_valid, locked, err
    );
endinterface

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with a registered-history rise pulse
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);
    logic [STAGES-1:0] chain;
    logic              s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            s_d   <= chain[STAGES-1];
        end
    end

    assign s    = chain[STAGES-1];
    assign rise = s & ~s_d;
endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures period/high time of a divided clock and tracks lock
module div_clk_monitor
    import div_pkg::*;
#(
    parameter int CNT_W       = DIV_CNT_W,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk_in,
    input  logic           rst,
    div_clk_monitor_if.slave mon
);
    localparam int               GW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    div_state_t       state, state_nxt;
    logic [GW-1:0]    gcnt, gcnt_nxt;
    logic [CNT_W-1:0] exp_r, pcnt, hcnt, period_r, high_r;
    logic             meas_valid_r, err_r;
    logic             s, rise, timeout, good;
    logic             capture, set_err, clr_cnt;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk_in),
        .rst  (rst),
        .d    (mon.mon_clk),
        .s    (s),
        .rise (rise)
    );

    assign timeout = (pcnt == CNT_MAX) && !rise;
    assign good    = (pcnt == exp_r) && good_high(32'(exp_r), 32'(hcnt));

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        capture   = 1'b0;
        set_err   = 1'b0;
        clr_cnt   = 1'b0;
        if (!mon.en) begin
            state_nxt = IDLE;
            gcnt_nxt  = '0;
            clr_cnt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                    gcnt_nxt  = '0;
                    clr_cnt   = 1'b1;
                end
                ARM: begin
                    if (timeout) begin
                        set_err = 1'b1;
                        clr_cnt = 1'b1;
                    end else if (rise) begin
                        state_nxt = MEAS;
                        gcnt_nxt  = '0;
                    end
                end
                MEAS, LOCKED: begin
                    if (timeout) begin
                        state_nxt = ARM;
                        gcnt_nxt  = '0;
                        set_err   = 1'b1;
                        clr_cnt   = 1'b1;
                    end else if (rise) begin
                        capture = 1'b1;
                        if (!good) begin
                            state_nxt = MEAS;
                            gcnt_nxt  = '0;
                            set_err   = 1'b1;
                        end else if (state == MEAS) begin
                            gcnt_nxt = gcnt + GW'(1);
                            if (gcnt == GW'(LOCK_CNT - 1))
                                state_nxt = LOCKED;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gcnt         <= '0;
            exp_r        <= '0;
            pcnt         <= '0;
            hcnt         <= '0;
            period_r     <= '0;
            high_r       <= '0;
            meas_valid_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state        <= state_nxt;
            gcnt         <= gcnt_nxt;
            meas_valid_r <= capture;
            // A new mismatch in the same cycle as a clear must not be lost.
            err_r        <= (err_r & ~mon.err_clr) | set_err;
            if (state == IDLE || state == ARM)
                exp_r <= mon.exp_period;
            if (capture) begin
                period_r <= pcnt;
                high_r   <= hcnt;
            end
            if (clr_cnt) begin
                pcnt <= '0;
                hcnt <= '0;
            end else if (rise) begin
                pcnt <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else begin
                pcnt <= (pcnt == CNT_MAX) ? pcnt : pcnt + CNT_W'(1);
                hcnt <= hcnt + CNT_W'(s);
            end
        end
    end

    assign mon.period_o   = period_r;
    assign mon.high_o     = high_r;
    assign mon.meas_valid = meas_valid_r;
    assign mon.locked     = (state == LOCKED);
    assign mon.err        = err_r;
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor
module tb_div_clk_monitor;
    import div_pkg::*;

    logic clk_in = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   gen_n  = 0;
    int   cur_n  = 0;
    int   ph     = 0;
    bit   found;

    div_clk_monitor_if #(.CNT_W(8)) mon();

    div_clk_monitor #(.CNT_W(8), .LOCK_CNT(4), .SYNC_STAGES(2)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .mon    (mon)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic wait_meas(input string tag);
        int n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
        end while (!mon.meas_valid && n < 60);
        chk({tag, "_wait"}, 32'(mon.meas_valid), 32'd1);
    endtask

    task automatic wait_lock(input string tag);
        int n = 0;
        while (!mon.locked && n < 40) begin
            wait_meas(tag);
            n++;
        end
        chk({tag, "_lock"}, 32'(mon.locked), 32'd1);
    endtask

    // Divided-clock source: period gen_n (0 = stuck low), ratio changes only on a period boundary.
    initial begin
        mon.mon_clk = 1'b0;
        forever begin
            @(negedge clk_in);
            if (gen_n == 0) begin
                cur_n = 0;
                ph = 0;
                mon.mon_clk = 1'b0;
            end else begin
                if (ph == 0) cur_n = gen_n;
                mon.mon_clk = (ph < (cur_n + 1) / 2);
                ph = (ph + 1 >= cur_n) ? 0 : ph + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mon.en = 1'b0;
        mon.exp_period = 8'd7;
        mon.err_clr = 1'b0;
        tick(3);
        chk("rst_period", 32'(mon.period_o), 32'd0);
        chk("rst_high", 32'(mon.high_o), 32'd0);
        chk("rst_valid", 32'(mon.meas_valid), 32'd0);
        chk("rst_locked", 32'(mon.locked), 32'd0);
        chk("rst_err", 32'(mon.err), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // Lock at N=7: arm rise plus four good measurements
        rst = 1'b0;
        mon.en = 1'b1;
        gen_n = 7;
        for (int i = 1; i <= 4; i++) begin
            wait_meas("s1");
            chk("s1_period", 32'(mon.period_o), 32'd7);
            chk("s1_high", 32'(mon.high_o), 32'd4);
            chk("s1_locked", 32'(mon.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("s1_err", 32'(mon.err), 32'd0);

        // Ratio drops to 5 while locked at 7
        gen_n = 7 - 2;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            wait_meas("s2");
            if (mon.period_o == 8'd5) found = 1'b1;
        end
        chk("s2_found", 32'(found), 32'd1);
        chk("s2_high", 32'(mon.high_o), 32'd3);
        chk("s2_locked", 32'(mon.locked), 32'd0);
        chk("s2_err", 32'(mon.err), 32'd1);
        mon.exp_period = 8'd5;
        repeat (5) wait_meas("s2b");
        chk("s2_nolock", 32'(mon.locked), 32'd0);
        mon.en = 1'b0;
        tick(1);
        chk("s2_idle", 32'(dut.state), 32'(IDLE));
        mon.en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_meas("s2c");
            chk("s2_relock", 32'(mon.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("s2_sticky", 32'(mon.err), 32'd1);

        // Lone clear pulse
        mon.err_clr = 1'b1;
        tick(1);
        mon.err_clr = 1'b0;
        chk("s4_clr", 32'(mon.err), 32'd0);
        chk("s4_clr_locked", 32'(mon.locked), 32'd1);

        // Stuck-low stall: timeout at pcnt saturation (255)
        gen_n = 0;
        tick(200);
        chk("s3_early_err", 32'(mon.err), 32'd0);
        chk("s3_early_locked", 32'(mon.locked), 32'd1);
        for (int n = 0; n < 100 && !mon.err; n++) tick(1);
        chk("s3_err", 32'(mon.err), 32'd1);
        chk("s3_locked", 32'(mon.locked), 32'd0);
        chk("s3_state", 32'(dut.state), 32'(ARM));

        // Relock at 7 from ARM, then a mismatch rise while err_clr is held
        mon.exp_period = 8'd7;
        gen_n = 7;
        wait_lock("s4r");
        mon.err_clr = 1'b1;
        tick(1);
        chk("s4_clean", 32'(mon.err), 32'd0);
        gen_n = 5;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            wait_meas("s4b");
            if (mon.period_o == 8'd5) found = 1'b1;
        end
        chk("s4b_found", 32'(found), 32'd1);
        chk("s4_coincide", 32'(mon.err), 32'd1);
        mon.err_clr = 1'b0;

        // One-cycle enable drop while locked
        gen_n = 7;
        wait_lock("s5p");
        mon.en = 1'b0;
        tick(1);
        chk("s5_drop_locked", 32'(mon.locked), 32'd0);
        chk("s5_hold_period", 32'(mon.period_o), 32'd7);
        mon.en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wait_meas("s5");
            chk("s5_relock", 32'(mon.locked), (i == 4) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset mid-period while locked
        tick(3);
        rst = 1'b1;
        #1;
        chk("s6_period", 32'(mon.period_o), 32'd0);
        chk("s6_high", 32'(mon.high_o), 32'd0);
        chk("s6_locked", 32'(mon.locked), 32'd0);
        chk("s6_err", 32'(mon.err), 32'd0);
        gen_n = 0;
        tick(3);
        rst = 1'b0;
        gen_n = 7;
        for (int i = 1; i <= 4; i++) begin
            wait_meas("s6");
            chk("s6_period_m", 32'(mon.period_o), 32'd7);
            chk("s6_locked_m", 32'(mon.locked), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("s6_err_end", 32'(mon.err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
